// File: rtl/sbqm_pkg.sv
// ============================================================================
// sbqm_pkg : shared encodings for the bank queue manager photocell front-end
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package sbqm_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DEB_BLK = 3'd1,
    BLOCKED = 3'd2,
    DEB_CLR = 3'd3,
    STUCK   = 3'd4
  } ch_state_e;

  // Photocells are active-low: a broken beam reads 0.
  localparam logic PC_BLOCKED = 1'b0;
  localparam logic PC_CLEAR   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/pc_channel.sv
// ============================================================================
// pc_channel : one photocell channel - synchroniser, debouncer, stuck detector
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module pc_channel
  import sbqm_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEB_CYCLES   = 4,
  parameter int STUCK_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic pc_raw,
  output logic pc_clean,
  output logic pulse,
  output logic stuck
);

  localparam int              DW       = $clog2(DEB_CYCLES + 1);
  localparam int              SW       = $clog2(STUCK_CYCLES + 1);
  localparam logic [DW-1:0]   DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [SW-1:0]   STK_LAST = SW'(STUCK_CYCLES - 1);
  localparam logic [SW-1:0]   STK_MAX  = SW'(STUCK_CYCLES);
  localparam logic            DEB_ONE  = (DEB_CYCLES == 1);

  logic [SYNC_STAGES-1:0] r_sync;
  ch_state_e              r_state;
  logic [DW-1:0]          r_deb_cnt;
  logic [SW-1:0]          r_stuck_cnt;
  logic                   w_s;
  logic [SW-1:0]          w_stuck_inc;
  logic                   w_stuck_hit;

  assign w_s         = r_sync[SYNC_STAGES-1];
  assign w_stuck_inc = (r_stuck_cnt == STK_MAX) ? r_stuck_cnt : r_stuck_cnt + 1'b1;
  assign w_stuck_hit = (r_stuck_cnt >= STK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync      <= '1;
      r_state     <= IDLE;
      r_deb_cnt   <= '0;
      r_stuck_cnt <= '0;
      pc_clean    <= PC_CLEAR;
      pulse       <= 1'b0;
      stuck       <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pc_raw};
      pulse  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_s == PC_BLOCKED) begin
            if (DEB_ONE) begin
              r_state     <= BLOCKED;
              pulse       <= 1'b1;
              pc_clean    <= PC_BLOCKED;
              r_stuck_cnt <= '0;
            end else begin
              r_state   <= DEB_BLK;
              r_deb_cnt <= DW'(1);
            end
          end
        end
        DEB_BLK: begin
          if (w_s == PC_CLEAR) begin
            r_state <= IDLE;
          end else if (r_deb_cnt == DEB_LAST) begin
            r_state     <= BLOCKED;
            pulse       <= 1'b1;
            pc_clean    <= PC_BLOCKED;
            r_stuck_cnt <= '0;
          end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
          end
        end
        // A completed release outranks the stuck timeout on the same edge.
        BLOCKED: begin
          if (w_s == PC_CLEAR && DEB_ONE) begin
            r_state  <= IDLE;
            pc_clean <= PC_CLEAR;
          end else if (w_stuck_hit) begin
            r_state   <= STUCK;
            stuck     <= 1'b1;
            r_deb_cnt <= (w_s == PC_CLEAR) ? DW'(1) : '0;
          end else begin
            r_stuck_cnt <= w_stuck_inc;
            if (w_s == PC_CLEAR) begin
              r_state   <= DEB_CLR;
              r_deb_cnt <= DW'(1);
            end
          end
        end
        DEB_CLR: begin
          if (w_s == PC_CLEAR && r_deb_cnt == DEB_LAST) begin
            r_state  <= IDLE;
            pc_clean <= PC_CLEAR;
          end else if (w_stuck_hit) begin
            r_state   <= STUCK;
            stuck     <= 1'b1;
            r_deb_cnt <= (w_s == PC_CLEAR) ? r_deb_cnt + 1'b1 : '0;
          end else begin
            r_stuck_cnt <= w_stuck_inc;
            if (w_s == PC_BLOCKED) begin
              r_state <= BLOCKED;
            end else begin
              r_deb_cnt <= r_deb_cnt + 1'b1;
            end
          end
        end
        STUCK: begin
          if (w_s == PC_CLEAR) begin
            if (r_deb_cnt == DEB_LAST) begin
              r_state  <= IDLE;
              stuck    <= 1'b0;
              pc_clean <= PC_CLEAR;
            end else begin
              r_deb_cnt <= r_deb_cnt + 1'b1;
            end
          end else begin
            r_deb_cnt <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_conditioner.sv
// ============================================================================
// pc_conditioner : front/back photocell conditioning for the queue counter
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module pc_conditioner #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEB_CYCLES   = 4,
  parameter int STUCK_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic frontPC,
  input  logic backPC,
  output logic front_clean,
  output logic back_clean,
  output logic down,
  output logic up,
  output logic front_stuck,
  output logic back_stuck
);

  pc_channel #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES),
    .STUCK_CYCLES(STUCK_CYCLES)
  ) u_front (
    .clk     (clk),
    .rst     (rst),
    .pc_raw  (frontPC),
    .pc_clean(front_clean),
    .pulse   (down),
    .stuck   (front_stuck)
  );

  pc_channel #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES),
    .STUCK_CYCLES(STUCK_CYCLES)
  ) u_back (
    .clk     (clk),
    .rst     (rst),
    .pc_raw  (backPC),
    .pc_clean(back_clean),
    .pulse   (up),
    .stuck   (back_stuck)
  );

endmodule

`default_nettype wire
